wb_pipe_reg: RTL and testbench

WB_PIPE_REG -- requirements
Module: wb_pipe_reg

---
 rtl/wb_pipe_reg.sv | 117 +++++++++++
 tb/tb_wb_pipe_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a two-entry skid buffer (head + skid), full valid/ready flow control.
// Optional stall counter enabled by defining WB_STALL_CNT_EN.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_reg_write,
  input  logic              m_mem_to_reg,
  input  logic [DATA_W-1:0] m_read_data,
  input  logic [DATA_W-1:0] m_alu_out,
  input  logic [ADDR_W-1:0] m_write_reg,
`ifdef WB_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr,
`endif
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_reg_write,
  output logic              w_mem_to_reg,
  output logic [DATA_W-1:0] w_read_data,
  output logic [DATA_W-1:0] w_alu_out,
  output logic [ADDR_W-1:0] w_write_reg,
  output logic [DATA_W-1:0] w_result
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_out;
    logic [ADDR_W-1:0] write_reg;
  } entry_t;

  occ_t   occ;
  entry_t head;
  entry_t skid;
  entry_t m_entry;
  logic   accept;
  logic   pop;

  assign m_entry = '{reg_write:  m_reg_write,
                     mem_to_reg: m_mem_to_reg,
                     read_data:  m_read_data,
                     alu_out:    m_alu_out,
                     write_reg:  m_write_reg};

  // Both handshakes depend only on registered occupancy, so w_ready never reaches m_ready.
  assign m_ready = (occ != TWO);
  assign w_valid = (occ != EMPTY);
  assign accept  = m_valid & m_ready & ~flush;
  assign pop     = w_valid & w_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ  <= EMPTY;
      // NOTE: payload is reset too, so an idle stage presents all-zero fields rather than X.
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      occ <= EMPTY;
    end else begin
      unique case (occ)
        EMPTY: if (accept) begin
          head <= m_entry;
          occ  <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            head <= m_entry;
          end else if (accept) begin
            skid <= m_entry;
            occ  <= TWO;
          end else if (pop) begin
            occ  <= EMPTY;
          end
        end
        TWO: if (pop) begin
          head <= skid;
          occ  <= ONE;
        end
        default: occ <= EMPTY;
      endcase
    end
  end

  assign w_reg_write  = head.reg_write & w_valid;
  assign w_mem_to_reg = head.mem_to_reg;
  assign w_read_data  = head.read_data;
  assign w_alu_out    = head.alu_out;
  assign w_write_reg  = head.write_reg;
  assign w_result     = head.mem_to_reg ? head.read_data : head.alu_out;

`ifdef WB_STALL_CNT_EN
  // Counts cycles the head is offered but refused; clear wins over increment, saturates at all-ones.
  always_ff @(posedge CLK) begin
    if (RST || stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (w_valid && !w_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Define WB_STALL_CNT_EN to exercise the counter.
module tb_wb_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef struct {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_out;
    logic [ADDR_W-1:0] write_reg;
  } ent_t;

  logic              CLK;
  logic              RST;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic              m_reg_write;
  logic              m_mem_to_reg;
  logic [DATA_W-1:0] m_read_data;
  logic [DATA_W-1:0] m_alu_out;
  logic [ADDR_W-1:0] m_write_reg;
  logic              w_valid;
  logic              w_ready;
  logic              w_reg_write;
  logic              w_mem_to_reg;
  logic [DATA_W-1:0] w_read_data;
  logic [DATA_W-1:0] w_alu_out;
  logic [ADDR_W-1:0] w_write_reg;
  logic [DATA_W-1:0] w_result;
`ifdef WB_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_cnt_clr;
`endif

  wb_pipe_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_reg_write  (m_reg_write),
    .m_mem_to_reg (m_mem_to_reg),
    .m_read_data  (m_read_data),
    .m_alu_out    (m_alu_out),
    .m_write_reg  (m_write_reg),
`ifdef WB_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
    .stall_cnt_clr(stall_cnt_clr),
`endif
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_reg_write  (w_reg_write),
    .w_mem_to_reg (w_mem_to_reg),
    .w_read_data  (w_read_data),
    .w_alu_out    (w_alu_out),
    .w_write_reg  (w_write_reg),
    .w_result     (w_result)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered queue of at most two entries.
  ent_t q[$];
  int   model_cnt = 0;

  always @(posedge CLK) begin
    int  sz;
    bit  do_pop;
    bit  do_acc;
    ent_t e;
    sz = q.size();
`ifdef WB_STALL_CNT_EN
    if (RST || stall_cnt_clr) model_cnt = 0;
    else if (sz > 0 && !w_ready && model_cnt < (1 << CNT_W) - 1) model_cnt++;
`endif
    if (RST || flush) begin
      q.delete();
    end else begin
      do_pop = (sz > 0) && w_ready;
      do_acc = m_valid && (sz < 2);
      if (do_pop) void'(q.pop_front());
      if (do_acc) begin
        e.reg_write  = m_reg_write;
        e.mem_to_reg = m_mem_to_reg;
        e.read_data  = m_read_data;
        e.alu_out    = m_alu_out;
        e.write_reg  = m_write_reg;
        q.push_back(e);
      end
    end
  end

  // Compare process: outputs are a function of registered state, checked mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("m_ready", 64'(m_ready), 64'(q.size() < 2));
      check("w_valid", 64'(w_valid), 64'(q.size() != 0));
      if (q.size() == 0) begin
        check("w_reg_write_idle", 64'(w_reg_write), 64'd0);
      end else begin
        check("w_reg_write",  64'(w_reg_write),  64'(q[0].reg_write));
        check("w_mem_to_reg", 64'(w_mem_to_reg), 64'(q[0].mem_to_reg));
        check("w_read_data",  64'(w_read_data),  64'(q[0].read_data));
        check("w_alu_out",    64'(w_alu_out),    64'(q[0].alu_out));
        check("w_write_reg",  64'(w_write_reg),  64'(q[0].write_reg));
        check("w_result",     64'(w_result),
              64'(q[0].mem_to_reg ? q[0].read_data : q[0].alu_out));
      end
`ifdef WB_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(model_cnt));
`endif
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic push(input logic [DATA_W-1:0] alu, input logic [ADDR_W-1:0] wr);
    m_valid      = 1'b1;
    m_reg_write  = 1'b1;
    m_mem_to_reg = 1'b0;
    m_read_data  = '0;
    m_alu_out    = alu;
    m_write_reg  = wr;
  endtask

  task automatic idle_in();
    m_valid     = 1'b0;
    m_reg_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_valid"},      64'(w_valid),      64'd0);
    check({tag, "_w_reg_write"},  64'(w_reg_write),  64'd0);
    check({tag, "_w_mem_to_reg"}, 64'(w_mem_to_reg), 64'd0);
    check({tag, "_w_read_data"},  64'(w_read_data),  64'd0);
    check({tag, "_w_alu_out"},    64'(w_alu_out),    64'd0);
    check({tag, "_w_write_reg"},  64'(w_write_reg),  64'd0);
    check({tag, "_w_result"},     64'(w_result),     64'd0);
    check({tag, "_m_ready"},      64'(m_ready),      64'd1);
  endtask

  initial begin
    logic [15:0] mv_pat;
    logic [15:0] wr_pat;
    RST = 1'b1; flush = 1'b0; w_ready = 1'b0;
    m_valid = 1'b0; m_reg_write = 1'b0; m_mem_to_reg = 1'b0;
    m_read_data = '0; m_alu_out = '0; m_write_reg = '0;
`ifdef WB_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    step(); step();
    RST = 1'b0;
    chk_en = 1'b1;
    check_reset_outputs("reset");

    // Single entry through an empty stage.
    push(32'h0000_00AA, 5'd3); w_ready = 1'b1;
    step();
    check("single_valid",  64'(w_valid),     64'd1);
    check("single_result", 64'(w_result),    64'h0000_00AA);
    check("single_wreg",   64'(w_write_reg), 64'd3);
    check("single_rw",     64'(w_reg_write), 64'd1);
    idle_in();
    step();
    check("single_empty",  64'(w_valid),     64'd0);

    // Back-pressure: A, B fill both slots, C is refused.
    w_ready = 1'b0;
    push(32'h11, 5'd1); step();
    check("bp_ready_one", 64'(m_ready), 64'd1);
    push(32'h22, 5'd2); step();
    check("bp_ready_two", 64'(m_ready), 64'd0);
    check("bp_head_a",    64'(w_result), 64'h11);
    push(32'h33, 5'd4); step();
    check("bp_still_a",   64'(w_result), 64'h11);
    check("bp_still_full", 64'(m_ready), 64'd0);
    idle_in(); w_ready = 1'b1; step();
    check("bp_head_b",    64'(w_result), 64'h22);
    check("bp_b_valid",   64'(w_valid),  64'd1);
    step();
    check("bp_drained",   64'(w_valid),  64'd0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      push(DATA_W'(i), ADDR_W'(i)); step();
      check("stream_result", 64'(w_result), 64'(i));
      check("stream_ready",  64'(m_ready),  64'd1);
    end
    idle_in(); step();
    check("stream_drained", 64'(w_valid), 64'd0);

    // Flush with both slots full and a same-cycle input.
    w_ready = 1'b0;
    push(32'h44, 5'd5); step();
    push(32'h55, 5'd6); step();
    push(32'h66, 5'd7); flush = 1'b1; step();
    check("flush_valid", 64'(w_valid),     64'd0);
    check("flush_rw",    64'(w_reg_write), 64'd0);
    check("flush_ready", 64'(m_ready),     64'd1);
    flush = 1'b0; idle_in(); step();
    check("flush_lost",  64'(w_valid),     64'd0);

    // Flush dominates pop and accept with one entry held.
    push(32'h77, 5'd8); step();
    w_ready = 1'b1; push(32'h88, 5'd9); flush = 1'b1; step();
    check("flush_pop_valid", 64'(w_valid), 64'd0);
    flush = 1'b0; idle_in(); w_ready = 1'b0;

    // Memory-data select.
    m_valid = 1'b1; m_reg_write = 1'b1; m_mem_to_reg = 1'b1;
    m_read_data = 32'hDEAD_BEEF; m_alu_out = 32'h0000_1234; m_write_reg = 5'd10;
    step();
    check("memsel_result", 64'(w_result), 64'hDEAD_BEEF);
    idle_in(); m_mem_to_reg = 1'b0; w_ready = 1'b1; step();
    check("memsel_drained", 64'(w_valid), 64'd0);

    // Mixed handshake patterns, checked by the model.
    mv_pat = 16'b1011_0110_1110_0101;
    wr_pat = 16'b0110_1011_0011_1100;
    for (int i = 0; i < 16; i++) begin
      m_valid = mv_pat[i]; m_reg_write = i[0]; m_mem_to_reg = i[1];
      m_read_data = 32'hA000_0000 + DATA_W'(i); m_alu_out = 32'h0B00 + DATA_W'(i);
      m_write_reg = ADDR_W'(i + 16);
      w_ready = wr_pat[i];
      step();
    end

    // Reset in the middle of a transfer drops both entries.
    w_ready = 1'b0;
    push(32'h99, 5'd11); step();
    push(32'hAB, 5'd12); step();
    push(32'hCD, 5'd13); RST = 1'b1; w_ready = 1'b1; step();
    check_reset_outputs("midrst");
    RST = 1'b0; idle_in(); step();
    check("midrst_after", 64'(w_valid), 64'd0);

`ifdef WB_STALL_CNT_EN
    w_ready = 1'b0;
    push(32'h5A, 5'd1); step();
    idle_in();
    repeat (20) step();
    check("stall_sat", 64'(stall_cnt), 64'd15);
    stall_cnt_clr = 1'b1; step();
    check("stall_clr", 64'(stall_cnt), 64'd0);
    stall_cnt_clr = 1'b0; step();
    check("stall_restart", 64'(stall_cnt), 64'd1);
    w_ready = 1'b1; step();
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
